// File: rtl/sram_wb_march_bist.sv
//------------------------------------------------------------------------------
// Module   : sram_wb_march_bist
// Purpose  : March C- built-in self-test master for a 32-bit Wishbone SRAM
//            wrapper. Runs w0 / r0,w1 / r1,w0 (up) then r0,w1 / r1,w0 / r0
//            (down) over every word (10*DEPTH accesses). It reports pass/fail
//            and the first failing word, then leaves the bus idle (cyc=0).
// Revision : 1.0 - initial release
//
// Parameters
//   DEPTH      number of 32-bit words tested
//   AW         word-index width (DEPTH <= 2**AW)
//   BASE_ADDR  byte address of word 0
//   PATTERN    data background "0"; "1" is ~PATTERN
//   TIMEOUT    ack watchdog limit in REQ cycles (watchdog build only)
//
// Ports
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   start_i              one-cycle pulse, accepted only when not busy
//   busy_o               test in progress (REQ or GAP)
//   done_o / pass_o      sticky completion flag / result (valid with done_o)
//   timeout_o            sticky ack-watchdog abort flag
//   fail_addr_o/_data_o  word index and read data of the first mismatch
//   wbm_*                Wishbone classic master port towards the wrapper
//
// Configuration macro
//   BIST_ACK_TIMEOUT_EN  enables the ack watchdog; without it REQ waits
//                        indefinitely and timeout_o is tied low.
//------------------------------------------------------------------------------
`default_nettype none

module sram_wb_march_bist #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned AW        = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] PATTERN   = 32'h0000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic          timeout_o,
  output logic [AW-1:0] fail_addr_o,
  output logic [31:0]   fail_data_o,
  output logic [31:0]   wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  input  logic [31:0]   wbm_dat_i,
  output logic [3:0]    wbm_sel_o,
  output logic          wbm_we_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  input  logic          wbm_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  state_t        state;
  logic [2:0]    elem;   // march element E0..E5
  logic          op;     // 0 = first operation of the element, 1 = second
  logic [AW-1:0] idx;    // current word index

  // Decode of the current element/operation
  logic          is_down;
  logic          is_read;
  logic          last_op;
  logic          elem_end;
  logic          final_acc;
  logic [31:0]   exp_data;
  logic [31:0]   wr_data;
  logic [2:0]    next_elem;
  logic          next_down;

  always_comb begin
    is_down   = (elem >= 3'd3);
    // E0 is write-only; every other element starts with a read
    is_read   = (elem != 3'd0) && !op;
    // E0 and E5 are single-operation elements
    last_op   = (elem == 3'd0) || (elem == 3'd5) || op;
    elem_end  = is_down ? (idx == '0) : (idx == LAST_IDX);
    final_acc = (elem == 3'd5) && (idx == '0);
    // E2/E4 read back the "1" background, E1/E3 write it
    exp_data  = ((elem == 3'd2) || (elem == 3'd4)) ? ~PATTERN : PATTERN;
    wr_data   = ((elem == 3'd1) || (elem == 3'd3)) ? ~PATTERN : PATTERN;
    next_elem = elem + 3'd1;
    next_down = (next_elem >= 3'd3);
  end

  // Address/data/we are derived from held state, so they stay stable for the
  // whole REQ phase; they are forced to zero whenever the cycle is idle.
  assign wbm_adr_o = wbm_cyc_o ? (BASE_ADDR + (32'(idx) << 2)) : 32'h0;
  assign wbm_we_o  = wbm_cyc_o && !is_read;
  assign wbm_dat_o = (wbm_cyc_o && !is_read) ? wr_data : 32'h0;
  assign wbm_sel_o = 4'hF;

`ifdef BIST_ACK_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
  logic          timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= S_IDLE;
      elem        <= 3'd0;
      op          <= 1'b0;
      idx         <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_addr_o <= '0;
      fail_data_o <= 32'h0;
`ifdef BIST_ACK_TIMEOUT_EN
      tcnt        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state       <= S_REQ;
            elem        <= 3'd0;
            op          <= 1'b0;
            idx         <= '0;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_data_o <= 32'h0;
`ifdef BIST_ACK_TIMEOUT_EN
            tcnt        <= '0;
            timeout_q   <= 1'b0;
`endif
          end
        end

        S_REQ: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            if (is_read && (wbm_dat_i != exp_data)) begin
              // First mismatch ends the test immediately, skipping GAP
              state       <= S_DONE;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              pass_o      <= 1'b0;
              fail_addr_o <= idx;
              fail_data_o <= wbm_dat_i;
            end else begin
              state <= S_GAP;
            end
`ifdef BIST_ACK_TIMEOUT_EN
          end else if (tcnt == TCNT_LAST) begin
            state       <= S_DONE;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            pass_o      <= 1'b0;
            timeout_q   <= 1'b1;
            fail_addr_o <= idx;
            fail_data_o <= 32'h0;
          end else begin
            tcnt <= tcnt + TW'(1);
`endif
          end
        end

        S_GAP: begin
          if (final_acc) begin
            // The access just completed was E5 at index 0
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= 1'b1;
          end else begin
            state     <= S_REQ;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
`ifdef BIST_ACK_TIMEOUT_EN
            tcnt      <= '0;
`endif
            if (!last_op) begin
              op <= 1'b1;
            end else begin
              op <= 1'b0;
              if (elem_end) begin
                // Element boundary: restart the index at the new element's
                // first word (E2->E3 stays at the top word).
                elem <= next_elem;
                idx  <= next_down ? LAST_IDX : '0;
              end else if (is_down) begin
                idx <= idx - IDX_ONE;
              end else begin
                idx <= idx + IDX_ONE;
              end
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_wb_march_bist.sv
//------------------------------------------------------------------------------
// Module   : tb_sram_wb_march_bist
// Purpose  : Directed self-checking bench for sram_wb_march_bist with an
//            8-word SRAM slave model (configurable ack delay, stuck-at bit,
//            no-ack mode) and an independent march-order reference.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sram_wb_march_bist;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, pass, tmo;
  logic [2:0]  fail_addr;
  logic [31:0] fail_data;
  logic [31:0] adr, dat_o, rdata;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic        ack = 1'b0;

  always #5 clk = ~clk;

  sram_wb_march_bist #(
    .DEPTH(8), .AW(3), .BASE_ADDR(32'h0), .PATTERN(32'h0), .TIMEOUT(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
    .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
    .fail_addr_o(fail_addr), .fail_data_o(fail_data),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(rdata),
    .wbm_sel_o(sel), .wbm_we_o(we), .wbm_cyc_o(cyc), .wbm_stb_o(stb),
    .wbm_ack_i(ack)
  );

  // Slave configuration
  int          ack_delay = 1;
  logic        no_ack = 1'b0;
  logic        stuck = 1'b0;

  // Slave state and observation counters
  logic [31:0] mem [8];
  int          wcnt = 0;
  int          ptr = 0;
  int          seq_err = 0;
  int          stab_err = 0;
  int          ack_total = 0;
  int          busy_total = 0;
  logic [31:0] hold_adr, hold_dat;
  logic        hold_we;
  logic        e_we;
  int          e_idx;
  logic [31:0] e_dat;

  int checks = 0;
  int errors = 0;

  // Reference March C- order for 8 words: access n -> (we, index, write data)
  function automatic void exp_access(input int n, output logic o_we,
                                     output int o_idx, output logic [31:0] o_dat);
    int m, e, r;
    o_we = 1'b0; o_idx = 0; o_dat = 32'h0;
    if (n < 8) begin
      o_we = 1'b1; o_idx = n; o_dat = 32'h0;
    end else if (n < 72) begin
      m = n - 8;
      e = 1 + m / 16;
      r = m % 16;
      o_idx = (e <= 2) ? (r / 2) : (7 - r / 2);
      o_we  = (r % 2) == 1;
      o_dat = (e == 1 || e == 3) ? 32'hFFFF_FFFF : 32'h0;
    end else begin
      o_idx = 7 - (n - 72);
    end
  endfunction

  always @(posedge clk) begin
    busy_total <= busy_total + (busy ? 1 : 0);
    if (ack && cyc) ack_total <= ack_total + 1;
    if (rst) begin
      ack  <= 1'b0;
      wcnt <= 0;
      ptr  <= 0;
    end else begin
      ack <= 1'b0;
      if (start && !busy) ptr <= 0;
      if (cyc && stb && !ack) begin
        if (wcnt == 0) begin
          hold_adr <= adr; hold_dat <= dat_o; hold_we <= we;
        end else if (adr !== hold_adr || dat_o !== hold_dat || we !== hold_we) begin
          stab_err <= stab_err + 1;
        end
        if (!no_ack && wcnt == ack_delay - 1) begin
          ack  <= 1'b1;
          wcnt <= 0;
          exp_access(ptr, e_we, e_idx, e_dat);
          if (we !== e_we || adr[4:2] !== e_idx[2:0] || adr[1:0] !== 2'b00 ||
              (we && dat_o !== e_dat) || sel !== 4'hF)
            seq_err <= seq_err + 1;
          ptr <= ptr + 1;
          if (we) mem[adr[4:2]] <= dat_o;
          else rdata <= (stuck && adr[4:2] == 3'd5) ? (mem[adr[4:2]] & ~32'h8)
                                                     : mem[adr[4:2]];
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, done}, 32'd1);
  endtask

  int a0, b0, n;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_pass", {31'b0, pass}, 32'd0);
    chk("rst_busy_cyc_stb_we", {28'b0, busy, cyc, stb, we}, 32'd0);
    chk("rst_sel", {28'b0, sel}, 32'hF);
    chk("rst_adr", adr, 32'h0);
    chk("rst_dat", dat_o, 32'h0);
    chk("rst_fail", {26'b0, tmo, fail_addr, 2'b0} | fail_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // T1: good memory, full run
    a0 = ack_total; b0 = busy_total;
    pulse_start();
    chk("t1_busy_after_start", {31'b0, busy}, 32'd1);
    wait_done("t1_done", 1000);
    chk("t1_pass", {31'b0, pass}, 32'd1);
    chk("t1_idle", {29'b0, busy, cyc, stb}, 32'd0);
    chk("t1_adr_idle", adr, 32'h0);
    chk("t1_acks", ack_total - a0, 32'd80);
    chk("t1_busy_cycles", busy_total - b0, 32'd240);
    chk("t1_order", seq_err, 32'd0);

    // T2: word 5 bit 3 stuck-at-0
    stuck = 1'b1;
    a0 = ack_total;
    pulse_start();
    wait_done("t2_done", 1000);
    chk("t2_pass", {31'b0, pass}, 32'd0);
    chk("t2_fail_addr", {29'b0, fail_addr}, 32'd5);
    chk("t2_fail_data", fail_data, 32'hFFFF_FFF7);
    chk("t2_acks", ack_total - a0, 32'd35);
    chk("t2_idle", {29'b0, busy, cyc, stb}, 32'd0);
    stuck = 1'b0;

    // T3: ack delayed 3 cycles
    ack_delay = 3;
    a0 = ack_total; b0 = busy_total;
    pulse_start();
    chk("t3_cleared", {30'b0, done, pass}, 32'd0);
    wait_done("t3_done", 2000);
    chk("t3_pass", {31'b0, pass}, 32'd1);
    chk("t3_busy_cycles", busy_total - b0, 32'd400);
    chk("t3_stable", stab_err, 32'd0);
    chk("t3_acks", ack_total - a0, 32'd80);
    ack_delay = 1;

    // T4: asynchronous reset in the middle of E3
    a0 = ack_total;
    pulse_start();
    n = 0;
    while ((ack_total - a0 < 43 || !cyc) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reached_e3", {31'b0, cyc}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t4_cyc_stb_async", {30'b0, cyc, stb}, 32'd0);
    chk("t4_flags", {29'b0, done, pass, busy}, 32'd0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("t4_stays_idle", {30'b0, busy, cyc}, 32'd0);
    a0 = ack_total;
    pulse_start();
    wait_done("t4_rerun_done", 1000);
    chk("t4_rerun_pass", {31'b0, pass}, 32'd1);
    chk("t4_rerun_acks", ack_total - a0, 32'd80);

    // T5: start while busy is ignored; start after done begins a new run
    a0 = ack_total; b0 = busy_total;
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_done("t5_done", 1000);
    chk("t5_pass", {31'b0, pass}, 32'd1);
    chk("t5_acks", ack_total - a0, 32'd80);
    chk("t5_busy_cycles", busy_total - b0, 32'd240);
    pulse_start();
    chk("t5_restart_clears_done", {30'b0, done, busy}, 32'd1);
    wait_done("t5_second_done", 1000);
    chk("t5_second_pass", {31'b0, pass}, 32'd1);
    chk("t5_order", seq_err, 32'd0);

`ifdef BIST_ACK_TIMEOUT_EN
    // T6: slave never acknowledges
    no_ack = 1'b1;
    a0 = ack_total; b0 = busy_total;
    pulse_start();
    wait_done("t6_done", 200);
    chk("t6_timeout", {31'b0, tmo}, 32'd1);
    chk("t6_pass", {31'b0, pass}, 32'd0);
    chk("t6_fail_addr", {29'b0, fail_addr}, 32'd0);
    chk("t6_fail_data", fail_data, 32'h0);
    chk("t6_req_cycles", busy_total - b0, 32'd16);
    chk("t6_idle", {30'b0, cyc, stb}, 32'd0);
    no_ack = 1'b0;
`else
    chk("timeout_tied_low", {31'b0, tmo}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
